// File: rtl/prim_sync_debounce.sv
// Debounce filter for a pre-synchronized level with edge pulses,
// a one-deep edge event slot and a sticky drop flag.
module prim_sync_debounce #(
  parameter int unsigned Threshold  = 4,
  parameter int unsigned CntWidth   = 4,
  parameter logic        ResetValue = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic sync_i,
  output logic filtered_o,
  output logic rise_o,
  output logic fall_o,
  output logic busy_o,
  output logic evt_valid_o,
  output logic evt_rise_o,
  input  logic evt_ready_i,
  output logic overflow_o,
  input  logic clr_overflow_i
);

  typedef enum logic {
    ST_STABLE,
    ST_QUAL
  } state_e;

  localparam logic [CntWidth-1:0] CntLast =
    CntWidth'(Threshold - 1);
  localparam logic [CntWidth-1:0] CntOne =
    CntWidth'(1);

  state_e              state_q;
  logic [CntWidth-1:0] cnt_q;

  logic differ;
  logic commit;
  logic xfer;
  logic drop;

  always_comb begin
    differ = (sync_i != filtered_o);
    commit = 1'b0;
    if (en_i && differ) begin
      if (state_q == ST_QUAL) begin
        commit = (cnt_q == CntLast);
      end else begin
        commit = (Threshold == 1);
      end
    end
    xfer = evt_valid_o && evt_ready_i;
    drop = commit && evt_valid_o && !evt_ready_i;
  end

  assign busy_o = (state_q == ST_QUAL);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_STABLE;
      cnt_q       <= '0;
      filtered_o  <= ResetValue;
      rise_o      <= 1'b0;
      fall_o      <= 1'b0;
      evt_valid_o <= 1'b0;
      evt_rise_o  <= 1'b0;
      overflow_o  <= 1'b0;
    end else begin
      rise_o <= 1'b0;
      fall_o <= 1'b0;

      if (!en_i) begin
        state_q <= ST_STABLE;
        cnt_q   <= '0;
      end else if (commit) begin
        filtered_o <= ~filtered_o;
        rise_o     <= ~filtered_o;
        fall_o     <= filtered_o;
        state_q    <= ST_STABLE;
        cnt_q      <= '0;
      end else begin
        unique case (state_q)
          ST_STABLE: begin
            if (differ) begin
              state_q <= ST_QUAL;
              cnt_q   <= CntOne;
            end
          end
          ST_QUAL: begin
            if (!differ) begin
              state_q <= ST_STABLE;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + CntOne;
            end
          end
          default: begin
            state_q <= ST_STABLE;
            cnt_q   <= '0;
          end
        endcase
      end

      // A full slot that is not draining keeps its event; new edge is lost
      if (commit && !drop) begin
        evt_valid_o <= 1'b1;
        evt_rise_o  <= ~filtered_o;
      end else if (xfer) begin
        evt_valid_o <= 1'b0;
      end

      if (drop) begin
        overflow_o <= 1'b1;
      end else if (clr_overflow_i) begin
        overflow_o <= 1'b0;
      end
    end
  end

endmodule
